dcache_readback_streamer: RTL and testbench

DCACHE_READBACK_STREAMER -- requirements
Module: dcache_readback_streamer

---
 rtl/dcache_rb_pkg.sv | 15 +
 rtl/readback_line_fifo.sv | 46 ++++
 rtl/dcache_readback_streamer.sv | 126 ++++++++++++
 tb/tb_dcache_readback_streamer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_rb_pkg.sv
// Shared types and widths for the dcache readback streamer.
package dcache_rb_pkg;
  localparam int LANES  = 8;
  localparam int LANE_W = 32;
  localparam int PIX_W  = 8;
  localparam int LINE_W = 256;
  localparam int ADDR_W = 28;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_SPACE,
    DONE
  } rb_state_t;
endpackage

// File: rtl/readback_line_fifo.sv
// Two-entry line buffer between cache reads and the pixel drain.
module readback_line_fifo
  import dcache_rb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [LINE_W-1:0] din,
  output logic [LINE_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  logic [LINE_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign dout    = mem[rd_ptr];
  // A push into a full buffer is legal only when the head leaves the same cycle.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/dcache_readback_streamer.sv
// Reads NUM_LINES cache lines and streams the low byte of each 32-bit lane as pixels.
// Optional nonzero-padding checker enabled by DCACHE_READBACK_CHECK_EN.
module dcache_readback_streamer
  import dcache_rb_pkg::*;
#(
  parameter int                NUM_LINES = 4800,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 28'h0000000,
  parameter logic [ADDR_W-1:0] ADDR_STEP = 28'd8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              done,
  input  logic [LINE_W-1:0] mem_data_rd1,
  output logic [ADDR_W-1:0] mem_data_addr1,
  output logic              mem_rw_data1,
  output logic              mem_valid_data1,
  input  logic              mem_ready_data1,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [15:0]       err_count
);
  rb_state_t         state;
  rb_state_t         state_nxt;
  logic [31:0]       line_idx;
  logic              gap;
  logic [2:0]        lane;
  logic [LINE_W-1:0] head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              mem_fire;
  logic              pix_accept;
  logic              pop;
  logic              start_ok;
  logic              last_line;
  logic              all_fetched;
  logic              full_after_push;
  logic              final_pop;

  readback_line_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (mem_fire),
    .pop   (pop),
    .din   (mem_data_rd1),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign mem_rw_data1    = 1'b0;
  assign mem_valid_data1 = (state == REQ) & ~gap;
  assign mem_fire        = mem_valid_data1 & mem_ready_data1;
  assign pix_valid       = ~fifo_empty;
  assign pix_data        = pix_valid ? head[{lane, 5'd0} +: PIX_W] : '0;
  assign pix_accept      = pix_valid & pix_ready;
  assign pop             = pix_accept & (lane == 3'd7);
  assign start_ok        = start & ((state == IDLE) | (state == DONE));
  assign last_line       = (line_idx == 32'(NUM_LINES - 1));
  assign all_fetched     = (line_idx == 32'(NUM_LINES));
  assign full_after_push = fifo_full | (~fifo_empty & ~pop);
  // Once every line is fetched, the final pop empties the buffer for good.
  assign final_pop       = pop & ~fifo_full;
  assign done            = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = REQ;
      REQ: begin
        if (mem_fire) begin
          if (last_line || full_after_push) state_nxt = WAIT_SPACE;
          else                              state_nxt = REQ;
        end
      end
      WAIT_SPACE: begin
        if (all_fetched) begin
          if (final_pop) state_nxt = DONE;
        end else if (!fifo_full) begin
          state_nxt = REQ;
        end
      end
      DONE: if (start) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      line_idx       <= '0;
      mem_data_addr1 <= BASE_ADDR;
      gap            <= 1'b0;
      lane           <= 3'd0;
    end else begin
      state <= state_nxt;
      // Hold the request low for one cycle after each capture.
      gap   <= mem_fire;
      if (start_ok) begin
        line_idx       <= '0;
        mem_data_addr1 <= BASE_ADDR;
        gap            <= 1'b0;
      end else if (mem_fire) begin
        line_idx       <= line_idx + 32'd1;
        mem_data_addr1 <= mem_data_addr1 + ADDR_STEP;
      end
      if (pix_accept) lane <= lane + 3'd1;
    end
  end

`ifdef DCACHE_READBACK_CHECK_EN
  logic [15:0] err_q;
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      err_q <= '0;
    end else if (pix_accept && (head[{lane, 5'd8} +: (LANE_W - PIX_W)] != '0)
                 && (err_q != 16'hFFFF)) begin
      err_q <= err_q + 16'd1;
    end
  end
  assign err_count = err_q;
`else
  assign err_count = '0;
`endif
endmodule

// File: tb/tb_dcache_readback_streamer.sv
// Bench for dcache_readback_streamer: table passes, randomized passes, reset and start corner cases.
module tb_dcache_readback_streamer;
  localparam int NL   = 4;
  localparam int BASE = 0;
  localparam int STEP = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         done;
  logic [255:0] mem_data_rd1;
  logic [27:0]  mem_data_addr1;
  logic         mem_rw_data1;
  logic         mem_valid_data1;
  logic         mem_ready_data1;
  logic [7:0]   pix_data;
  logic         pix_valid;
  logic         pix_ready;
  logic [15:0]  err_count;

  dcache_readback_streamer #(
    .NUM_LINES (NL),
    .BASE_ADDR (28'(BASE)),
    .ADDR_STEP (28'(STEP))
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .done            (done),
    .mem_data_rd1    (mem_data_rd1),
    .mem_data_addr1  (mem_data_addr1),
    .mem_rw_data1    (mem_rw_data1),
    .mem_valid_data1 (mem_valid_data1),
    .mem_ready_data1 (mem_ready_data1),
    .pix_data        (pix_data),
    .pix_valid       (pix_valid),
    .pix_ready       (pix_ready),
    .err_count       (err_count)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  logic [255:0] line_mem [NL];
  int           mem_lat = 2;
  bit           mem_en  = 1'b0;
  int           mem_wc  = 0;
  int           addr_q[$];

  typedef struct {
    int lat;
    int rmode;      // 0: always ready, 1: random, 2: held low for 20 cycles
    int pat;        // 0: lane k = k+1, 1: same with padding error in line 0 lane 3, 2: random
    int mid_start;  // cycle of a stray start pulse, -1 for none
    int exp_first;  // expected first pixel, -1 when taken from the model
    int exp_err;    // expected err_count with checker on, -1 when taken from the model
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Cache model: answers each request after mem_lat cycles of valid.
  initial begin
    int idx;
    forever begin
      @(negedge clk);
      if (mem_en) begin
        if (mem_ready_data1) begin
          mem_ready_data1 = 1'b0;
          mem_wc = 0;
        end else if (mem_valid_data1) begin
          if (mem_wc >= mem_lat) begin
            idx = int'(mem_data_addr1) / STEP;
            addr_q.push_back(int'(mem_data_addr1));
            mem_data_rd1    = line_mem[idx % NL];
            mem_ready_data1 = 1'b1;
          end else begin
            mem_wc++;
          end
        end
      end
    end
  end

  function automatic void build(input int pat);
    for (int i = 0; i < NL; i++) begin
      for (int k = 0; k < 8; k++) begin
        logic [31:0] w;
        if (pat == 2) begin
          w[7:0]  = 8'($urandom);
          w[31:8] = ($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'd0;
        end else begin
          w = 32'(k + 1);
        end
        line_mem[i][32*k +: 32] = w;
      end
    end
    if (pat == 1) line_mem[0][32*3 +: 32] = 32'h0100_0055;
  endfunction

  task automatic run_pass(input int lat, input int rmode, input int mid_start,
                          input int exp_first, input int exp_err_tbl);
    byte unsigned exp_pix[$];
    int   model_err;
    int   exp_e;
    bit   fin;
    bit   last_acc;
    bit   first;
    bit   stall_prev;
    logic [7:0] prev_data;

    model_err = 0;
    for (int i = 0; i < NL; i++)
      for (int k = 0; k < 8; k++) begin
        exp_pix.push_back(line_mem[i][32*k +: 8]);
        if (line_mem[i][32*k+8 +: 24] != 24'd0) model_err++;
      end
`ifdef DCACHE_READBACK_CHECK_EN
    exp_e = (exp_err_tbl >= 0) ? exp_err_tbl : model_err;
`else
    exp_e = 0;
`endif
    mem_lat = lat;
    addr_q.delete();

    @(negedge clk);
    pix_ready = 1'b0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("start_valid", mem_valid_data1, 1);
    chk("start_addr", mem_data_addr1, BASE);
    chk("start_done_clr", done, 0);
    chk("start_err_clr", err_count, 0);

    fin = 0; last_acc = 0; first = 1; stall_prev = 0; prev_data = '0;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      @(negedge clk);
      start = (cyc == mid_start);
      if (rmode == 0)      pix_ready = 1'b1;
      else if (rmode == 1) pix_ready = 1'($urandom_range(0, 1));
      else                 pix_ready = (cyc >= 20);
      #1;
      if (last_acc) begin
        chk("done_after_last", done, 1);
        chk("pix_valid_at_done", pix_valid, 0);
        chk("err_count", err_count, exp_e);
        fin = 1;
      end else begin
        chk("done_early", done, 0);
        if (stall_prev) chk("stall_stable", pix_data, prev_data);
        if (rmode == 2 && cyc == 19) begin
          chk("hold_lines_fetched", addr_q.size(), 2);
          chk("hold_valid_low", mem_valid_data1, 0);
        end
        if (pix_valid && pix_ready) begin
          if (exp_pix.size() == 0) begin
            chk("extra_pixel", 1, 0);
          end else begin
            if (first && exp_first >= 0) chk("first_pix", pix_data, exp_first);
            chk("pix_data", pix_data, exp_pix.pop_front());
            first = 0;
            if (exp_pix.size() == 0) last_acc = 1;
          end
        end
        stall_prev = pix_valid && !pix_ready;
        prev_data  = pix_data;
      end
    end
    start = 1'b0;
    chk("pass_finished", fin, 1);
    chk("addr_count", addr_q.size(), NL);
    for (int i = 0; i < NL && i < addr_q.size(); i++)
      chk("addr_seq", addr_q[i], BASE + i * STEP);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{lat: 2, rmode: 0, pat: 0, mid_start: -1, exp_first: 1, exp_err: 0};
    vecs[1] = '{lat: 2, rmode: 2, pat: 0, mid_start: -1, exp_first: 1, exp_err: 0};
    vecs[2] = '{lat: 1, rmode: 0, pat: 1, mid_start: 3,  exp_first: 1, exp_err: 1};
    vecs[3] = '{lat: 0, rmode: 1, pat: 0, mid_start: -1, exp_first: 1, exp_err: 0};
    vecs[4] = '{lat: 3, rmode: 1, pat: 1, mid_start: 6,  exp_first: 1, exp_err: 1};

    rst = 1'b1; start = 1'b0; pix_ready = 1'b0;
    mem_ready_data1 = 1'b0; mem_data_rd1 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_valid", mem_valid_data1, 0);
    chk("rst_addr", mem_data_addr1, BASE);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_pix_data", pix_data, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_count, 0);
    chk("rw_is_read", mem_rw_data1, 0);

    // Reset during an outstanding read; a late response must be dropped.
    build(0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 10 && !mem_valid_data1; i++) @(negedge clk);
    #1;
    chk("pre_rst_valid", mem_valid_data1, 1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_valid", mem_valid_data1, 0);
    chk("mid_rst_addr", mem_data_addr1, BASE);
    mem_data_rd1    = line_mem[0];
    mem_ready_data1 = 1'b1;
    @(negedge clk);
    mem_ready_data1 = 1'b0;
    #1;
    chk("late_ready_no_capture", pix_valid, 0);
    chk("late_ready_idle", mem_valid_data1, 0);
    mem_wc = 0;
    mem_en = 1'b1;

    for (int v = 0; v < 5; v++) begin
      build(vecs[v].pat);
      run_pass(vecs[v].lat, vecs[v].rmode, vecs[v].mid_start,
               vecs[v].exp_first, vecs[v].exp_err);
    end

    for (int p = 0; p < 6; p++) begin
      build(2);
      run_pass(int'($urandom_range(0, 3)), 1, -1, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
